decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage for the 32-bit RISC core; successor to the combinational opcode/funct decoder.
- Turns opcode + funct + register fields into the control bundle (tipo, MemtoReg, functout, RegWrite, rsSource, ALUsrc, Branch, MemWrite).
- Adds valid/ready handshake, load-use interlock with a parametrised bubble count, branch flush, and a saturating stall counter.
- Sits between the fetch register and the execute stage.

Parameters:
- OPC_W, 4, opcode width; opcodes 6..2^OPC_W-1 are illegal.
- FUNCT_W, 3, funct field width; functout has the same width.
- RA_W, 5, register-address width for rs/rt/rd.
- STALL_CYCLES, 1, bubbles inserted on a load-use hazard; legal range 1..3.
- SCNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  stage accepts the instruction this cycle.
- opcode  in  OPC_W  instruction opcode.
- functin  in  FUNCT_W  funct field.
- rs, rt, rd  in  RA_W each  source and destination register numbers.
- flush  in  1  branch taken; kill the stage contents.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute stage consumes the bundle.
- tipo  out  2  format: 00 R, 01 I, 10 branch, 11 jump.
- MemtoReg, RegWrite, rsSource, ALUsrc, Branch, MemWrite  out  1 each  registered controls.
- functout  out  FUNCT_W  ALU function.
- rs_q, rt_q, rd_q  out  RA_W each  registered register fields.
- stall_cnt  out  SCNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, state RUN, load-pending flag 0, stall counter 0.
- Decode table (unlisted controls are 0):
  - op0 R-type: tipo=00, RegWrite=1, functout=functin.
  - op1 ADDI: tipo=01, ALUsrc=1, RegWrite=1, functout=000.
  - op2 LW: tipo=01, ALUsrc=1, MemtoReg=1, RegWrite=1, functout=000.
  - op3 SW: tipo=01, ALUsrc=1, MemWrite=1, functout=000.
  - op4 BEQ: tipo=10, Branch=1, functout=001.
  - op5 JMP: tipo=11, Branch=1, rsSource=1.
  - Other opcodes: all controls 0 (NOP), out_valid still asserted.
- Latency: one cycle. An accepted instruction appears on the outputs the next edge.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
- The output register loads on accept. If out_valid && !out_ready, the output holds and is stable. If out_ready is high and nothing is accepted, out_valid drops to 0.
- Load tracking: accepting LW with rd!=0 sets ld_pend=1 and ld_rd=rd. Accepting any other instruction clears ld_pend.
- Hazard: in RUN with in_valid && ld_pend && (rs==ld_rd || rt==ld_rd):
  - in_ready=0 for that cycle; go to STALL with counter=STALL_CYCLES-1.
  - Clear ld_pend; stall_cnt increments.
- STALL state:
  - in_ready=0; each cycle stall_cnt increments, saturating at all-ones.
  - The output register drains normally; no new bundle is loaded.
  - Counter reaches 0: return to RUN next edge.
  - Total bubbles = STALL_CYCLES.
- flush (synchronous, highest priority):
  - next edge: out_valid=0, state=RUN, ld_pend=0, stall counter cleared.
  - Controls are also zeroed; the input is not accepted in the flush cycle.
- Flush at the same time as a hazard: flush wins; no STALL entry, stall_cnt unchanged.
- Reset mid-stall aborts immediately to the reset state.

Optional Feature:
- Macro DECODE_ILLEGAL_TRAP_EN.
- Defined: extra output port illegal (1 bit, registered, reset 0). It is 1 alongside the NOP bundle for opcodes 6..2^OPC_W-1, and is cleared by flush.
- Undefined: the port is absent; illegal opcodes decode silently as NOP.

Decomposition:
- Package decode_pkg holds:
  - opcode constants OP_RTYPE..OP_JMP;
  - tipo encodings TIPO_R/I/B/J;
  - a packed ctrl_t struct with all control fields;
  - state enum RUN/STALL.
- Sub-module decode_rom: purely combinational opcode/funct to ctrl_t table, instantiated once. The stage wraps it with handshake, interlock and counter.

Test Plan:
- Reset, then stream op0..op5 with functin=101, out_ready=1 → one-cycle latency bundles. op0 functout=101; op2 MemtoReg=1, RegWrite=1; op5 rsSource=1, tipo=11.
- LW rd=7, then ADD rs=7 → one bubble (out_valid=0 for 1 cycle), in_ready=0 for 1 cycle, stall_cnt=1. Repeat with STALL_CYCLES=3 → 3 bubbles, stall_cnt=3.
- LW rd=0, then ADD rs=0 → no stall. LW rd=4, then ADD rs=5, rt=6 → no stall.
- out_ready=0 for 4 cycles with out_valid=1 → outputs stable, in_ready=0. Release → next instruction accepted on the following edge.
- flush during STALL and during a hazard cycle → out_valid=0 next edge, state RUN, in_ready=1 the cycle after.
- Opcode 4'hF with DECODE_ILLEGAL_TRAP_EN → illegal=1, all controls 0. Without the macro → NOP bundle; stall_cnt saturation checked with SCNT_W=2.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode numbers, instruction formats, control bundle and stage states.
package decode_pkg;

    localparam int OP_RTYPE = 0;
    localparam int OP_ADDI  = 1;
    localparam int OP_LW    = 2;
    localparam int OP_SW    = 3;
    localparam int OP_BEQ   = 4;
    localparam int OP_JMP   = 5;

    localparam logic [1:0] TIPO_R = 2'b00;
    localparam logic [1:0] TIPO_I = 2'b01;
    localparam logic [1:0] TIPO_B = 2'b10;
    localparam logic [1:0] TIPO_J = 2'b11;

    // The ALU function is carried beside this struct because its width is a module parameter.
    typedef struct packed {
        logic [1:0] tipo;
        logic       mem_to_reg;
        logic       reg_write;
        logic       rs_source;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

endpackage

// File: rtl/decode_rom.sv
// Combinational opcode/funct to control-bundle table; unknown opcodes decode as an all-zero NOP.
module decode_rom
    import decode_pkg::*;
#(
    parameter int OPC_W   = 4,
    parameter int FUNCT_W = 3
) (
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] functin,
    output ctrl_t              ctrl,
    output logic [FUNCT_W-1:0] functout
);

    always_comb begin
        ctrl     = '0;
        functout = '0;
        case (opcode)
            OPC_W'(OP_RTYPE): begin
                ctrl.tipo      = TIPO_R;
                ctrl.reg_write = 1'b1;
                functout       = functin;
            end
            OPC_W'(OP_ADDI): begin
                ctrl.tipo      = TIPO_I;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_W'(OP_LW): begin
                ctrl.tipo       = TIPO_I;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OPC_W'(OP_SW): begin
                ctrl.tipo      = TIPO_I;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OPC_W'(OP_BEQ): begin
                ctrl.tipo   = TIPO_B;
                ctrl.branch = 1'b1;
                functout    = FUNCT_W'(1);
            end
            OPC_W'(OP_JMP): begin
                ctrl.tipo      = TIPO_J;
                ctrl.branch    = 1'b1;
                ctrl.rs_source = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, load-use interlock, branch flush and stall counter.
// Optional DECODE_ILLEGAL_TRAP_EN adds a registered 'illegal' flag for opcodes above OP_JMP.
module decode_stage
    import decode_pkg::*;
#(
    parameter int OPC_W        = 4,
    parameter int FUNCT_W      = 3,
    parameter int RA_W         = 5,
    parameter int STALL_CYCLES = 1,
    parameter int SCNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNCT_W-1:0] functin,
    input  logic [RA_W-1:0]    rs,
    input  logic [RA_W-1:0]    rt,
    input  logic [RA_W-1:0]    rd,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         tipo,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               rsSource,
    output logic               ALUsrc,
    output logic               Branch,
    output logic               MemWrite,
    output logic [FUNCT_W-1:0] functout,
    output logic [RA_W-1:0]    rs_q,
    output logic [RA_W-1:0]    rt_q,
    output logic [RA_W-1:0]    rd_q,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic               illegal,
`endif
    output logic [SCNT_W-1:0]  stall_cnt
);

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               ld_pend_q, ld_pend_d;
    logic [RA_W-1:0]    ld_rd_q, ld_rd_d;
    logic [SCNT_W-1:0]  stall_cnt_q, stall_cnt_d, stall_cnt_inc;
    logic               out_valid_q, out_valid_d;
    ctrl_t              ctrl_q, ctrl_d, rom_ctrl;
    logic [FUNCT_W-1:0] functout_q, functout_d, rom_funct;
    logic [RA_W-1:0]    rs_d, rt_d, rd_d;
    logic               hazard, accept;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic               illegal_q, illegal_d;
`endif

    decode_rom #(
        .OPC_W   (OPC_W),
        .FUNCT_W (FUNCT_W)
    ) u_rom (
        .opcode   (opcode),
        .functin  (functin),
        .ctrl     (rom_ctrl),
        .functout (rom_funct)
    );

    assign hazard        = (state_q == RUN) && in_valid && ld_pend_q && (rs == ld_rd_q || rt == ld_rd_q);
    assign in_ready      = (state_q == RUN) && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept        = in_valid && in_ready;
    assign stall_cnt_inc = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + SCNT_W'(1);

    // The hazard cycle itself is the first bubble, so STALL only covers the remaining STALL_CYCLES-1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ld_pend_d   = ld_pend_q;
        ld_rd_d     = ld_rd_q;
        stall_cnt_d = stall_cnt_q;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        functout_d  = functout_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        if (flush) begin
            state_d     = RUN;
            cnt_d       = '0;
            ld_pend_d   = 1'b0;
            out_valid_d = 1'b0;
            ctrl_d      = '0;
            functout_d  = '0;
            rs_d        = '0;
            rt_d        = '0;
            rd_d        = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_d   = 1'b0;
`endif
        end else begin
            if (accept) begin
                out_valid_d = 1'b1;
                ctrl_d      = rom_ctrl;
                functout_d  = rom_funct;
                rs_d        = rs;
                rt_d        = rt;
                rd_d        = rd;
                ld_pend_d   = (opcode == OPC_W'(OP_LW)) && (rd != '0);
                ld_rd_d     = rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal_d   = opcode > OPC_W'(OP_JMP);
`endif
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (hazard) begin
                        ld_pend_d   = 1'b0;
                        stall_cnt_d = stall_cnt_inc;
                        if (STALL_CYCLES > 1) begin
                            state_d = STALL;
                            cnt_d   = 2'(STALL_CYCLES - 1);
                        end
                    end
                end
                STALL: begin
                    stall_cnt_d = stall_cnt_inc;
                    cnt_d       = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            ld_pend_q   <= 1'b0;
            ld_rd_q     <= '0;
            stall_cnt_q <= '0;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            functout_q  <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ld_pend_q   <= ld_pend_d;
            ld_rd_q     <= ld_rd_d;
            stall_cnt_q <= stall_cnt_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            functout_q  <= functout_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign tipo      = ctrl_q.tipo;
    assign MemtoReg  = ctrl_q.mem_to_reg;
    assign RegWrite  = ctrl_q.reg_write;
    assign rsSource  = ctrl_q.rs_source;
    assign ALUsrc    = ctrl_q.alu_src;
    assign Branch    = ctrl_q.branch;
    assign MemWrite  = ctrl_q.mem_write;
    assign functout  = functout_q;
    assign stall_cnt = stall_cnt_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with a single-bubble interlock, one with
// three bubbles and a 2-bit stall counter. Illegal-flag checks follow DECODE_ILLEGAL_TRAP_EN.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] opcode = '0;
    logic [2:0] functin = '0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_m2r, a_rw, a_rss, a_alus, a_br, a_mw;
    logic [1:0]  a_tipo;
    logic [2:0]  a_functout;
    logic [4:0]  a_rs_q, a_rt_q, a_rd_q;
    logic [15:0] a_stall_cnt;
    logic        b_in_ready, b_out_valid, b_m2r, b_rw, b_rss, b_alus, b_br, b_mw;
    logic [1:0]  b_tipo;
    logic [2:0]  b_functout;
    logic [4:0]  b_rs_q, b_rt_q, b_rd_q;
    logic [1:0]  b_stall_cnt;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        a_illegal, b_illegal;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.STALL_CYCLES(1), .SCNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .opcode(opcode), .functin(functin), .rs(rs), .rt(rt), .rd(rd), .flush(flush),
        .out_valid(a_out_valid), .out_ready(out_ready), .tipo(a_tipo),
        .MemtoReg(a_m2r), .RegWrite(a_rw), .rsSource(a_rss), .ALUsrc(a_alus),
        .Branch(a_br), .MemWrite(a_mw), .functout(a_functout),
        .rs_q(a_rs_q), .rt_q(a_rt_q), .rd_q(a_rd_q),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal(a_illegal),
`endif
        .stall_cnt(a_stall_cnt)
    );

    decode_stage #(.STALL_CYCLES(3), .SCNT_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .opcode(opcode), .functin(functin), .rs(rs), .rt(rt), .rd(rd), .flush(flush),
        .out_valid(b_out_valid), .out_ready(out_ready), .tipo(b_tipo),
        .MemtoReg(b_m2r), .RegWrite(b_rw), .rsSource(b_rss), .ALUsrc(b_alus),
        .Branch(b_br), .MemWrite(b_mw), .functout(b_functout),
        .rs_q(b_rs_q), .rt_q(b_rt_q), .rd_q(b_rd_q),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal(b_illegal),
`endif
        .stall_cnt(b_stall_cnt)
    );

    // Bundle layout: {tipo, MemtoReg, RegWrite, rsSource, ALUsrc, Branch, MemWrite, functout}
    function automatic logic [10:0] bundleA();
        return {a_tipo, a_m2r, a_rw, a_rss, a_alus, a_br, a_mw, a_functout};
    endfunction

    function automatic logic [10:0] bundleB();
        return {b_tipo, b_m2r, b_rw, b_rss, b_alus, b_br, b_mw, b_functout};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [2:0] fn,
                                 input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                 input logic fl, input logic ordy);
        in_valid  = v;
        opcode    = op;
        functin   = fn;
        rs        = s;
        rt        = t;
        rd        = d;
        flush     = fl;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] expBundle [6];

    initial begin
        expBundle[0] = 11'b00_010000_101;
        expBundle[1] = 11'b01_010100_000;
        expBundle[2] = 11'b01_110100_000;
        expBundle[3] = 11'b01_000101_000;
        expBundle[4] = 11'b10_000010_001;
        expBundle[5] = 11'b11_001010_000;

        // Reset state of the single-bubble instance
        applyStimulus(0, 4'h0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 1);
        tick(); tick();
        checkOutput("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        checkOutput("rst_bundle", {21'd0, bundleA()}, 32'd0);
        checkOutput("rst_stall_cnt", {16'd0, a_stall_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 4'(i), 3'b101, 5'd1, 5'd2, 5'd3, 0, 1);
            checkOutput($sformatf("stream_in_ready_%0d", i), {31'd0, a_in_ready}, 32'd1);
            tick();
            checkOutput($sformatf("stream_valid_%0d", i), {31'd0, a_out_valid}, 32'd1);
            checkOutput($sformatf("stream_bundle_%0d", i), {21'd0, bundleA()}, {21'd0, expBundle[i]});
        end
        checkOutput("stream_rd_q", {27'd0, a_rd_q}, 32'd3);

        // LW r7 followed by a dependent ADD: one bubble
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd7, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b010, 5'd7, 5'd1, 5'd8, 0, 1);
        checkOutput("hz1_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        checkOutput("hz1_bubble", {31'd0, a_out_valid}, 32'd0);
        checkOutput("hz1_stall_cnt", {16'd0, a_stall_cnt}, 32'd1);
        checkOutput("hz1_in_ready_after", {31'd0, a_in_ready}, 32'd1);
        tick();
        checkOutput("hz1_valid", {31'd0, a_out_valid}, 32'd1);
        checkOutput("hz1_rd_q", {27'd0, a_rd_q}, 32'd8);
        checkOutput("hz1_functout", {29'd0, a_functout}, 32'd2);

        // r0 loads and unrelated registers never interlock
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd0, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b000, 5'd0, 5'd0, 5'd1, 0, 1);
        checkOutput("lw_r0_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd4, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b000, 5'd5, 5'd6, 5'd1, 0, 1);
        checkOutput("lw_r4_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        checkOutput("no_stall_cnt", {16'd0, a_stall_cnt}, 32'd1);

        // Backpressure: ADDI r9 held for four cycles while BEQ waits
        applyStimulus(1, 4'h1, 3'b000, 5'd2, 5'd0, 5'd9, 0, 1);
        tick();
        applyStimulus(1, 4'h4, 3'b000, 5'd1, 5'd2, 5'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_valid_%0d", i), {31'd0, a_out_valid}, 32'd1);
            checkOutput($sformatf("bp_bundle_%0d", i), {21'd0, bundleA()}, {21'd0, expBundle[1]});
            checkOutput($sformatf("bp_rd_q_%0d", i), {27'd0, a_rd_q}, 32'd9);
            checkOutput($sformatf("bp_in_ready_%0d", i), {31'd0, a_in_ready}, 32'd0);
            tick();
        end
        applyStimulus(1, 4'h4, 3'b000, 5'd1, 5'd2, 5'd0, 0, 1);
        checkOutput("bp_release_in_ready", {31'd0, a_in_ready}, 32'd1);
        tick();
        checkOutput("bp_release_bundle", {21'd0, bundleA()}, {21'd0, expBundle[4]});

        // Flush coinciding with a hazard: no stall is counted
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd7, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b001, 5'd7, 5'd0, 5'd10, 1, 1);
        checkOutput("fh_in_ready", {31'd0, a_in_ready}, 32'd0);
        tick();
        checkOutput("fh_valid", {31'd0, a_out_valid}, 32'd0);
        checkOutput("fh_bundle", {21'd0, bundleA()}, 32'd0);
        checkOutput("fh_stall_cnt", {16'd0, a_stall_cnt}, 32'd1);
        applyStimulus(1, 4'h0, 3'b001, 5'd7, 5'd0, 5'd10, 0, 1);
        checkOutput("fh_in_ready_after", {31'd0, a_in_ready}, 32'd1);
        tick();
        checkOutput("fh_rd_q", {27'd0, a_rd_q}, 32'd10);

        // Opcode 4'hF decodes as a NOP bundle
        applyStimulus(1, 4'hF, 3'b111, 5'd1, 5'd1, 5'd1, 0, 1);
        tick();
        checkOutput("ill_valid", {31'd0, a_out_valid}, 32'd1);
        checkOutput("ill_bundle", {21'd0, bundleA()}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkOutput("ill_flag", {31'd0, a_illegal}, 32'd1);
`endif
        applyStimulus(0, 4'h0, 3'b000, 5'd0, 5'd0, 5'd0, 1, 1);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        checkOutput("ill_flag_flushed", {31'd0, a_illegal}, 32'd0);
`endif
        checkOutput("ill_valid_flushed", {31'd0, a_out_valid}, 32'd0);

        // Three-bubble instance with a 2-bit stall counter, fresh from reset
        applyStimulus(0, 4'h0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("b_rst_stall_cnt", {30'd0, b_stall_cnt}, 32'd0);
        checkOutput("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd7, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b000, 5'd1, 5'd7, 5'd2, 0, 1);
        checkOutput("b_hz_in_ready", {31'd0, b_in_ready}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("b_bubble_%0d", i), {31'd0, b_out_valid}, 32'd0);
            checkOutput($sformatf("b_stall_cnt_%0d", i), {30'd0, b_stall_cnt}, 32'(i));
            checkOutput($sformatf("b_in_ready_%0d", i), {31'd0, b_in_ready}, (i == 3) ? 32'd1 : 32'd0);
        end
        tick();
        checkOutput("b_valid_after_stall", {31'd0, b_out_valid}, 32'd1);
        checkOutput("b_rd_q", {27'd0, b_rd_q}, 32'd2);

        // Second hazard saturates the counter, then a flush aborts the stall
        applyStimulus(1, 4'h2, 3'b000, 5'd0, 5'd0, 5'd7, 0, 1);
        tick();
        applyStimulus(1, 4'h0, 3'b000, 5'd7, 5'd0, 5'd3, 0, 1);
        tick();
        checkOutput("b_sat_stall_cnt", {30'd0, b_stall_cnt}, 32'd3);
        checkOutput("b_stall_in_ready", {31'd0, b_in_ready}, 32'd0);
        applyStimulus(1, 4'h0, 3'b000, 5'd7, 5'd0, 5'd3, 1, 1);
        tick();
        checkOutput("b_flush_valid", {31'd0, b_out_valid}, 32'd0);
        checkOutput("b_flush_stall_cnt", {30'd0, b_stall_cnt}, 32'd3);
        applyStimulus(1, 4'h0, 3'b000, 5'd7, 5'd0, 5'd3, 0, 1);
        checkOutput("b_flush_in_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        checkOutput("b_flush_accept", {31'd0, b_out_valid}, 32'd1);
        checkOutput("b_flush_rd_q", {27'd0, b_rd_q}, 32'd3);
        checkOutput("b_flush_bundle", {21'd0, bundleB()}, 32'b00_010000_000);

        applyStimulus(0, 4'h0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 1);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
